// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: round-robin sharing of one 8x8 approximate multiplier.
// Optional macro APPROX_MUL_ERRSTAT_EN adds resp_exact and err_cnt outputs.

// Approximate unsigned 8x8 multiply. Conf_Bit_Mask[c] keeps partial-product
// column c (c = 0..5); a cleared bit drops that column. Columns 6..15 are
// always exact, so mask 6'h3F yields the exact product.
module unsigned_int_mul (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [5:0]  Conf_Bit_Mask,
    output logic [15:0] R
);
    logic [15:0] keep;

    // Sum the shifted partial products with low columns gated by the mask.
    always_comb begin
        keep = {10'h3FF, Conf_Bit_Mask};
        R    = '0;
        for (int j = 0; j < 8; j++) begin
            R = R + ((16'(A & {8{B[j]}}) << j) & keep);
        end
    end
endmodule

module approx_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*8-1:0] req_A,
    input  logic [N_REQ*8-1:0] req_B,
    input  logic [N_REQ*6-1:0] req_mask,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [15:0]        resp_R,
    output logic [ID_W-1:0]    resp_id
`ifdef APPROX_MUL_ERRSTAT_EN
    ,
    output logic [15:0]        resp_exact,
    output logic [31:0]        err_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t          state_q;
    logic [ID_W-1:0] last_grant_q;
    logic [7:0]      a_q, b_q;
    logic [5:0]      mask_q;
    logic [ID_W-1:0] id_q;
    logic [15:0]     resp_r_q;
    logic [ID_W-1:0] resp_id_q;
    logic            resp_valid_q;

    logic [ID_W-1:0] win_d;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            opp;
    logic            grant;
    logic [7:0]      a_d, b_d;
    logic [5:0]      m_sel, mask_d;
    logic [15:0]     mul_r;

    // Round-robin search upward from the last grant, wrapping at N_REQ-1.
    always_comb begin
        win_d = last_grant_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win_d = idx;
            end
        end
    end

    assign opp   = (state_q == IDLE) ||
                   ((state_q == RESP) && resp_ready);
    assign grant = opp && found && !rst;

    // Steer the winner's operands and drive its one-hot accept.
    always_comb begin
        a_d       = '0;
        b_d       = '0;
        m_sel     = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d == ID_W'(i)) begin
                a_d          = req_A[i*8 +: 8];
                b_d          = req_B[i*8 +: 8];
                m_sel        = req_mask[i*6 +: 6];
                req_ready[i] = grant;
            end
        end
        mask_d = (m_sel == 6'd0) ? 6'd1 : m_sel;
    end

    unsigned_int_mul u_mul (
        .A             (a_q),
        .B             (b_q),
        .Conf_Bit_Mask (mask_q),
        .R             (mul_r)
    );

    // Sequencer: capture on grant, multiply for one cycle, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            mask_q       <= '0;
            id_q         <= '0;
            resp_r_q     <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            if (grant) begin
                a_q          <= a_d;
                b_q          <= b_d;
                mask_q       <= mask_d;
                id_q         <= win_d;
                last_grant_q <= win_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (grant) state_q <= MUL;
                end
                MUL: begin
                    resp_r_q     <= mul_r;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= grant ? MUL : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_R     = resp_r_q;
    assign resp_id    = resp_id_q;

`ifdef APPROX_MUL_ERRSTAT_EN
    logic [15:0] exact_q;
    logic [31:0] err_q;

    // Exact product alongside the result; count saturating mismatches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact_q <= '0;
            err_q   <= '0;
        end else begin
            if (state_q == MUL) exact_q <= {8'd0, a_q} * {8'd0, b_q};
            if (resp_valid_q && resp_ready &&
                (resp_r_q != exact_q) && (err_q != 32'hFFFF_FFFF))
                err_q <= err_q + 32'd1;
        end
    end

    assign resp_exact = exact_q;
    assign err_cnt    = err_q;
`endif
endmodule
